pe_array_feed_scheduler: RTL and testbench

Sequencer that drives the 27-bit interleaved feed port of the 3x3 binary PE array (kernel_27). Each 12-cycle frame carries 9 weight words in slots 0-8 and 3 activation words in slots 9-11.
- Holds a double-buffered 9-word weight bank and pulls activations over a valid/ready stream.
- Controls the array's active-low reset so the array's internal slot counter is always aligned with the scheduler's.
- Captures the three psum sign bits once per frame and presents them as a result.

---
 rtl/pe_array_feed_scheduler_if.sv | 26 ++
 rtl/pe_array_feed_scheduler.sv | 148 ++++++++++++++
 tb/tb_pe_array_feed_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_feed_scheduler_if.sv
// Feed-side bundle of the PE array scheduler: activation stream, array feed and result.
// The master modport is the scheduler; the slave modport is the array/stream environment.
interface pe_array_feed_scheduler_if #(
    parameter int DATA_W = 27
);
    logic              act_valid_in;
    logic [DATA_W-1:0] act_data_in;
    logic              act_ready_out;
    logic              arr_rst_n_out;
    logic [DATA_W-1:0] arr_data_out;
    logic              psum_row_0_in;
    logic              psum_row_1_in;
    logic              psum_row_2_in;
    logic              res_valid_out;
    logic [2:0]        res_out;

    modport master (
        input  act_valid_in, act_data_in, psum_row_0_in, psum_row_1_in, psum_row_2_in,
        output act_ready_out, arr_rst_n_out, arr_data_out, res_valid_out, res_out
    );

    modport slave (
        output act_valid_in, act_data_in, psum_row_0_in, psum_row_1_in, psum_row_2_in,
        input  act_ready_out, arr_rst_n_out, arr_data_out, res_valid_out, res_out
    );
endinterface

// File: rtl/pe_array_feed_scheduler.sv
// 12-slot frame sequencer for the 3x3 PE array: 9 weight slots then 3 activation slots.
// Latency: feed is combinational from slot; result strobes one cycle after slot RES_SLOT of the next frame.
// Backpressure: none toward the array; a missing activation is fed as 0 and marks the frame bubble.
// Optional underrun counter enabled by PE_SCHED_UNDERRUN_CNT_EN.
module pe_array_feed_scheduler #(
    parameter int DATA_W   = 27,
    parameter int RES_SLOT = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic              wt_wr_en_in,
    input  logic [3:0]        wt_addr_in,
    input  logic [DATA_W-1:0] wt_data_in,
    input  logic              wt_commit_in,
    output logic              wt_commit_pending_out,
    output logic              busy_out,
    output logic [3:0]        slot_out,
    output logic [15:0]       underrun_cnt_out,
    pe_array_feed_scheduler_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [3:0] RES_SLOT_L = 4'(RES_SLOT);
    localparam logic [3:0] LAST_SLOT  = 4'd11;

    state_t            state, state_nxt;
    logic [3:0]        slot;
    logic              stop_latched, smp_done;
    logic              prev_vld, prev_bubble, cur_bubble;
    logic              pending, commit_now;
    logic              act_slot, underrun;
    logic [DATA_W-1:0] shadow     [9];
    logic [DATA_W-1:0] shadow_nxt [9];
    logic [DATA_W-1:0] active     [9];

    assign act_slot              = (slot >= 4'd9);
    assign bus.act_ready_out     = (state == RUN) && act_slot;
    assign underrun              = bus.act_ready_out && !bus.act_valid_in;
    assign busy_out              = (state != IDLE);
    assign slot_out              = slot;
    assign wt_commit_pending_out = pending;

    // A commit is applied at once in IDLE, otherwise only on a frame boundary.
    assign commit_now = (wt_commit_in || pending) &&
                        ((state == IDLE) || (slot == LAST_SLOT));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = RUN;
            RUN:     if (slot == LAST_SLOT && (stop_latched || stop_in)) state_nxt = DRAIN;
            DRAIN:   if (smp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        bus.arr_data_out = '0;
        if (state != IDLE) begin
            if (!act_slot)
                bus.arr_data_out = active[slot];
            else if (bus.act_ready_out && bus.act_valid_in)
                bus.arr_data_out = bus.act_data_in;
        end
    end

    always_comb begin
        shadow_nxt = shadow;
        if (wt_wr_en_in && wt_addr_in < 4'd9)
            shadow_nxt[wt_addr_in] = wt_data_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot              <= '0;
            stop_latched      <= 1'b0;
            smp_done          <= 1'b0;
            prev_vld          <= 1'b0;
            prev_bubble       <= 1'b0;
            cur_bubble        <= 1'b0;
            pending           <= 1'b0;
            bus.arr_rst_n_out <= 1'b0;
            bus.res_valid_out <= 1'b0;
            bus.res_out       <= '0;
            shadow            <= '{default: '0};
            active            <= '{default: '0};
        end else begin
            bus.arr_rst_n_out <= (state_nxt != IDLE);
            slot <= (state == IDLE || state_nxt == IDLE || slot == LAST_SLOT) ? 4'd0 : slot + 4'd1;

            if (state == IDLE)
                stop_latched <= start_in && stop_in;
            else if (state == RUN && state_nxt == DRAIN)
                stop_latched <= 1'b0;
            else if (state == RUN && stop_in)
                stop_latched <= 1'b1;

            smp_done <= (state == DRAIN) && (slot == RES_SLOT_L);

            // Per-frame bubble tracking; the drain frame never becomes a predecessor.
            if (state == IDLE) begin
                prev_vld    <= 1'b0;
                prev_bubble <= 1'b0;
                cur_bubble  <= 1'b0;
            end else if (slot == LAST_SLOT) begin
                prev_vld    <= (state == RUN);
                prev_bubble <= cur_bubble || underrun;
                cur_bubble  <= 1'b0;
            end else if (underrun) begin
                cur_bubble  <= 1'b1;
            end

            bus.res_valid_out <= 1'b0;
            if (state != IDLE && slot == RES_SLOT_L && prev_vld && !prev_bubble) begin
                bus.res_valid_out <= 1'b1;
                bus.res_out       <= {bus.psum_row_2_in, bus.psum_row_1_in, bus.psum_row_0_in};
            end

            shadow  <= shadow_nxt;
            pending <= (pending || wt_commit_in) && !commit_now;
            if (commit_now) active <= shadow_nxt;
        end
    end

`ifdef PE_SCHED_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || (state == IDLE && start_in))
            urun_cnt <= '0;
        else if (underrun && urun_cnt != 16'hFFFF)
            urun_cnt <= urun_cnt + 16'd1;
    end

    assign underrun_cnt_out = urun_cnt;
`else
    assign underrun_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pe_array_feed_scheduler.sv
// Directed bench for pe_array_feed_scheduler: per-cycle vector table for a full
// three-frame run plus drain, and hand-written sequences for one-frame start/stop and mid-frame reset.
module tb_pe_array_feed_scheduler;
    localparam int DW = 27;

    logic          clk_in = 1'b0;
    logic          rst_in, start_in, stop_in, wt_wr_en_in, wt_commit_in;
    logic [3:0]    wt_addr_in;
    logic [DW-1:0] wt_data_in;
    logic          wt_commit_pending_out, busy_out;
    logic [3:0]    slot_out;
    logic [15:0]   underrun_cnt_out;

    always #5 clk_in = ~clk_in;

    pe_array_feed_scheduler_if #(.DATA_W(DW)) bus ();

    pe_array_feed_scheduler #(.DATA_W(DW), .RES_SLOT(4)) dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .start_in              (start_in),
        .stop_in               (stop_in),
        .wt_wr_en_in           (wt_wr_en_in),
        .wt_addr_in            (wt_addr_in),
        .wt_data_in            (wt_data_in),
        .wt_commit_in          (wt_commit_in),
        .wt_commit_pending_out (wt_commit_pending_out),
        .busy_out              (busy_out),
        .slot_out              (slot_out),
        .underrun_cnt_out      (underrun_cnt_out),
        .bus                   (bus)
    );

    typedef struct {
        logic          start, stop, commit, wr_en;
        logic [3:0]    addr;
        logic [DW-1:0] wdat;
        logic          act_vld;
        logic [DW-1:0] act_dat;
        logic [2:0]    psum;
        logic          e_rst_n;
        logic [DW-1:0] e_data;
        logic          e_rdy;
        logic [3:0]    e_slot;
        logic          e_busy, e_rv;
        logic [2:0]    e_res;
        logic          e_pend;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, got, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic e_rst_n, input logic [DW-1:0] e_data,
                           input logic e_rdy, input logic [3:0] e_slot, input logic e_busy,
                           input logic e_rv, input logic [2:0] e_res, input logic e_pend);
        chk("arr_rst_n", idx, 32'(bus.arr_rst_n_out), 32'(e_rst_n));
        chk("arr_data",  idx, 32'(bus.arr_data_out),  32'(e_data));
        chk("act_ready", idx, 32'(bus.act_ready_out), 32'(e_rdy));
        chk("slot",      idx, 32'(slot_out),          32'(e_slot));
        chk("busy",      idx, 32'(busy_out),          32'(e_busy));
        chk("res_valid", idx, 32'(bus.res_valid_out), 32'(e_rv));
        chk("res",       idx, 32'(bus.res_out),       32'(e_res));
        chk("pending",   idx, 32'(wt_commit_pending_out), 32'(e_pend));
    endtask

    task automatic idle_inputs();
        start_in = 0; stop_in = 0; wt_wr_en_in = 0; wt_addr_in = '0; wt_data_in = '0;
        wt_commit_in = 0; bus.act_valid_in = 0; bus.act_data_in = '0;
        {bus.psum_row_2_in, bus.psum_row_1_in, bus.psum_row_0_in} = 3'b000;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   n_busy, n_rdy, n_strb;

        // Main run: start cycle, frames 1..3, drain frame (slots 0..5), one IDLE cycle.
        v = '{default: '0};
        v.start = 1; v.act_vld = 1; v.psum = 3'b111;
        tbl.push_back(v);
        for (int f = 1; f <= 4; f++) begin
            for (int s = 0; s < ((f == 4) ? 6 : 12); s++) begin
                v = '{default: '0};
                v.act_vld = 1; v.act_dat = DW'(27'h999); v.psum = 3'b111;
                v.e_rst_n = 1; v.e_busy = 1; v.e_slot = 4'(s);
                if (s < 9) v.e_data = (f > 1 && s == 0) ? 27'h7FFFFFF : DW'(s + 1);
                if (s >= 9 && f < 4) begin
                    v.e_rdy   = 1;
                    v.act_dat = DW'(32'h0A50000 + f * 256 + s);
                    v.e_data  = v.act_dat;
                end
                v.e_res  = (f == 1 || (f == 2 && s < 5)) ? 3'b000 :
                           (f == 4 && s == 5) ? 3'b110 : 3'b101;
                v.e_rv   = (s == 5) && (f == 2 || f == 4);
                v.e_pend = (f == 1) && (s >= 4);
                if (f == 1 && s == 3)  v.commit = 1;
                if (f == 1 && s == 11) begin
                    v.commit = 1; v.wr_en = 1; v.addr = 4'd0; v.wdat = 27'h7FFFFFF;
                end
                if (f == 2 && s == 4)  v.psum = 3'b101;
                if (f == 2 && s == 10) begin
                    v.act_vld = 0; v.act_dat = DW'(27'h5555); v.e_data = '0;
                end
                if (f == 3 && s == 3)  v.stop = 1;
                if (f == 3 && s == 4)  v.psum = 3'b010;
                if (f == 4 && s == 4)  v.psum = 3'b110;
                tbl.push_back(v);
            end
        end
        v = '{default: '0};
        v.act_vld = 1; v.act_dat = DW'(27'h999); v.psum = 3'b111; v.e_res = 3'b110;
        tbl.push_back(v);

        // Reset, then idle
        idle_inputs();
        rst_in = 1;
        repeat (3) next_cycle();
        rst_in = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            chk_all(i, 0, '0, 0, 4'd0, 0, 0, 3'b000, 0);
            chk("underrun_cnt", i, 32'(underrun_cnt_out), 32'd0);
            next_cycle();
        end

        // Load shadow 1..9 and commit while idle
        for (int i = 0; i < 9; i++) begin
            wt_wr_en_in = 1; wt_addr_in = 4'(i); wt_data_in = DW'(i + 1);
            next_cycle();
        end
        wt_wr_en_in = 0; wt_commit_in = 1;
        next_cycle();
        wt_commit_in = 0;
        @(negedge clk_in);
        chk("idle_commit_pending", 0, 32'(wt_commit_pending_out), 32'd0);
        next_cycle();

        foreach (tbl[i]) begin
            start_in = tbl[i].start; stop_in = tbl[i].stop; wt_commit_in = tbl[i].commit;
            wt_wr_en_in = tbl[i].wr_en; wt_addr_in = tbl[i].addr; wt_data_in = tbl[i].wdat;
            bus.act_valid_in = tbl[i].act_vld; bus.act_data_in = tbl[i].act_dat;
            {bus.psum_row_2_in, bus.psum_row_1_in, bus.psum_row_0_in} = tbl[i].psum;
            @(negedge clk_in);
            chk_all(i, tbl[i].e_rst_n, tbl[i].e_data, tbl[i].e_rdy, tbl[i].e_slot,
                    tbl[i].e_busy, tbl[i].e_rv, tbl[i].e_res, tbl[i].e_pend);
            next_cycle();
        end
`ifdef PE_SCHED_UNDERRUN_CNT_EN
        chk("underrun_cnt_run", 0, 32'(underrun_cnt_out), 32'd1);
`else
        chk("underrun_cnt_run", 0, 32'(underrun_cnt_out), 32'd0);
`endif

        // start and stop together: exactly one frame, then a drain frame
        idle_inputs();
        start_in = 1; stop_in = 1; bus.act_valid_in = 1; bus.act_data_in = DW'(27'h321);
        {bus.psum_row_2_in, bus.psum_row_1_in, bus.psum_row_0_in} = 3'b011;
        next_cycle();
        start_in = 0; stop_in = 0;
        n_busy = 0; n_rdy = 0; n_strb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (busy_out) n_busy++;
            if (bus.act_ready_out) n_rdy++;
            if (bus.res_valid_out) begin
                n_strb++;
                chk("one_frame_res", c, 32'(bus.res_out), 32'(3'b011));
                chk("one_frame_res_slot", c, 32'(slot_out), 32'd5);
            end
            next_cycle();
        end
        chk("one_frame_busy_cycles", 0, 32'(n_busy), 32'd18);
        chk("one_frame_ready_cycles", 0, 32'(n_rdy), 32'd3);
        chk("one_frame_strobes", 0, 32'(n_strb), 32'd1);
        chk("underrun_cnt_cleared", 0, 32'(underrun_cnt_out), 32'd0);
        chk("one_frame_arr_rst_n", 0, 32'(bus.arr_rst_n_out), 32'd0);

        // Mid-frame reset with a commit pending and a held result
        start_in = 1;
        next_cycle();
        start_in = 0;
        for (int c = 0; c < 6; c++) begin
            wt_commit_in = (c == 2);
            next_cycle();
        end
        wt_commit_in = 0; rst_in = 1;
        @(negedge clk_in);
        chk("pre_reset_slot", 0, 32'(slot_out), 32'd6);
        chk("pre_reset_pending", 0, 32'(wt_commit_pending_out), 32'd1);
        next_cycle();
        @(negedge clk_in);
        chk_all(100, 0, '0, 0, 4'd0, 0, 0, 3'b000, 0);
        chk("reset_underrun_cnt", 0, 32'(underrun_cnt_out), 32'd0);
        next_cycle();
        rst_in = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
